// File: rtl/ahblite_master_stage.sv
// ahblite_master_stage
//   Per-master front end of the 1-master-to-16-slave AHB-Lite matrix.
//   It decodes the master address into a one-hot slave request and drives
//   the gated address-phase signals that the slave stages consume. It tracks
//   the master's data phase and muxes HREADY/HRESP/HRDATA back. An address
//   that loses arbitration is parked in hold registers until its slave
//   accepts it. Unmapped accesses get the two-cycle ERROR response from the
//   built-in default slave.
//
// Ports
//   HCLK, HRESETN          clock, asynchronous active-low reset
//   HADDR..HMASTLOCK       master address-phase inputs
//   HREADY, HRESP, HRDATA  data-phase response to the master
//   GATED*                 live address-phase signals to the slave stages
//   ADDRSEL                one-hot address-phase slave request
//   DATASEL                one-hot slave owning the current data phase
//   PREVDATASLAVEREADY     current data phase completes this cycle
//   SADDRREADY             per-slave address-ready from the slave stages
//   SDATAREADY             per-slave data-ready from the slave stages
//   SHRESP, SHRDATA        per-slave response and read data (slave n at [32n+31:32n])

module ahblite_master_stage #(
  parameter logic [15:0] SLAVE_EN = 16'hFFFF,
  parameter int          DEC_MSB  = 31
) (
  input  logic         HCLK,
  input  logic         HRESETN,
  input  logic [31:0]  HADDR,
  input  logic [1:0]   HTRANS,
  input  logic         HWRITE,
  input  logic [2:0]   HSIZE,
  input  logic         HMASTLOCK,
  output logic         HREADY,
  output logic         HRESP,
  output logic [31:0]  HRDATA,
  output logic [31:0]  GATEDHADDR,
  output logic         GATEDHTRANS,
  output logic         GATEDHWRITE,
  output logic [2:0]   GATEDHSIZE,
  output logic         GATEDHMASTLOCK,
  output logic [15:0]  ADDRSEL,
  output logic [15:0]  DATASEL,
  output logic         PREVDATASLAVEREADY,
  input  logic [15:0]  SADDRREADY,
  input  logic [15:0]  SDATAREADY,
  input  logic [15:0]  SHRESP,
  input  logic [511:0] SHRDATA
);

  typedef enum logic [1:0] {
    D_NONE,
    D_SLAVE,
    D_ERR1,
    D_ERR2
  } dstate_t;

  dstate_t     dstate, dstate_nxt;
  logic [3:0]  dslv, dslv_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic        hold_capture;
  logic [31:0] hold_addr;
  logic        hold_write;
  logic [2:0]  hold_size;
  logic        hold_lock;
  logic [3:0]  hold_slv;

  logic [3:0]  slv;
  logic        mapped;
  logic        valid;
  logic        req;
  logic        data_ok;

  // Only bit 1 of HTRANS matters here; BUSY and IDLE are treated alike.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];

  // A parked address takes priority over whatever the master is presenting;
  // a parked transfer is by construction a valid one.
  assign slv    = hold_valid ? hold_slv : HADDR[DEC_MSB -: 4];
  assign mapped = SLAVE_EN[slv];
  assign valid  = hold_valid | HTRANS[1];
  assign req    = valid & mapped;

  assign GATEDHADDR     = hold_valid ? hold_addr  : HADDR;
  assign GATEDHWRITE    = hold_valid ? hold_write : HWRITE;
  assign GATEDHSIZE     = hold_valid ? hold_size  : HSIZE;
  assign GATEDHMASTLOCK = hold_valid ? hold_lock  : HMASTLOCK;
  assign GATEDHTRANS    = req;
  assign ADDRSEL        = req ? (16'd1 << slv) : 16'd0;

  assign PREVDATASLAVEREADY = data_ok;

  // Data-phase response mux and next-state decision. The master address is
  // only sampled when the master sees HREADY high, which can never happen
  // while an address is parked.
  always_comb begin
    HREADY         = 1'b1;
    HRESP          = 1'b0;
    HRDATA         = 32'd0;
    DATASEL        = 16'd0;
    data_ok        = 1'b1;
    dstate_nxt     = dstate;
    dslv_nxt       = dslv;
    hold_valid_nxt = hold_valid;
    hold_capture   = 1'b0;

    case (dstate)
      D_SLAVE: begin
        data_ok = SDATAREADY[dslv];
        HREADY  = SDATAREADY[dslv];
        HRESP   = SHRESP[dslv];
        HRDATA  = SHRDATA[{dslv, 5'd0} +: 32];
        DATASEL = 16'd1 << dslv;
      end
      D_ERR1: begin
        data_ok = 1'b0;
        HREADY  = 1'b0;
        HRESP   = 1'b1;
      end
      D_ERR2: begin
        HRESP   = 1'b1;
      end
      default: begin
        HREADY  = !hold_valid;
      end
    endcase

    if (hold_valid) begin
      // HREADY stays low in the release cycle; the master's own address
      // becomes live on the following cycle.
      if (SADDRREADY[slv]) begin
        hold_valid_nxt = 1'b0;
        dstate_nxt     = D_SLAVE;
        dslv_nxt       = slv;
      end
    end else if (HREADY) begin
      if (req && SADDRREADY[slv]) begin
        dstate_nxt = D_SLAVE;
        dslv_nxt   = slv;
      end else if (req) begin
        hold_capture   = 1'b1;
        hold_valid_nxt = 1'b1;
        dstate_nxt     = D_NONE;
      end else if (valid) begin
        dstate_nxt = D_ERR1;
      end else begin
        dstate_nxt = D_NONE;
      end
    end else if (dstate == D_ERR1) begin
      dstate_nxt = D_ERR2;
    end
  end

  // State and hold registers; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      dstate     <= D_NONE;
      dslv       <= 4'd0;
      hold_valid <= 1'b0;
      hold_addr  <= 32'd0;
      hold_write <= 1'b0;
      hold_size  <= 3'd0;
      hold_lock  <= 1'b0;
      hold_slv   <= 4'd0;
    end else begin
      dstate     <= dstate_nxt;
      dslv       <= dslv_nxt;
      hold_valid <= hold_valid_nxt;
      if (hold_capture) begin
        hold_addr  <= HADDR;
        hold_write <= HWRITE;
        hold_size  <= HSIZE;
        hold_lock  <= HMASTLOCK;
        hold_slv   <= HADDR[DEC_MSB -: 4];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_master_stage.sv
// tb_ahblite_master_stage
//   Directed scenarios for the master stage followed by a long randomized
//   run compared cycle by cycle against a transaction-level model.

module tb_ahblite_master_stage;

  localparam logic [15:0] SLAVE_EN_TB = 16'h00FF;

  logic         HCLK;
  logic         HRESETN;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic         HMASTLOCK;
  logic         HREADY;
  logic         HRESP;
  logic [31:0]  HRDATA;
  logic [31:0]  GATEDHADDR;
  logic         GATEDHTRANS;
  logic         GATEDHWRITE;
  logic [2:0]   GATEDHSIZE;
  logic         GATEDHMASTLOCK;
  logic [15:0]  ADDRSEL;
  logic [15:0]  DATASEL;
  logic         PREVDATASLAVEREADY;
  logic [15:0]  SADDRREADY;
  logic [15:0]  SDATAREADY;
  logic [15:0]  SHRESP;
  logic [511:0] SHRDATA;

  int n_checks = 0;
  int n_errors = 0;

  ahblite_master_stage #(
    .SLAVE_EN(SLAVE_EN_TB),
    .DEC_MSB (31)
  ) dut (
    .HCLK              (HCLK),
    .HRESETN           (HRESETN),
    .HADDR             (HADDR),
    .HTRANS            (HTRANS),
    .HWRITE            (HWRITE),
    .HSIZE             (HSIZE),
    .HMASTLOCK         (HMASTLOCK),
    .HREADY            (HREADY),
    .HRESP             (HRESP),
    .HRDATA            (HRDATA),
    .GATEDHADDR        (GATEDHADDR),
    .GATEDHTRANS       (GATEDHTRANS),
    .GATEDHWRITE       (GATEDHWRITE),
    .GATEDHSIZE        (GATEDHSIZE),
    .GATEDHMASTLOCK    (GATEDHMASTLOCK),
    .ADDRSEL           (ADDRSEL),
    .DATASEL           (DATASEL),
    .PREVDATASLAVEREADY(PREVDATASLAVEREADY),
    .SADDRREADY        (SADDRREADY),
    .SDATAREADY        (SDATAREADY),
    .SHRESP            (SHRESP),
    .SHRDATA           (SHRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Model of the master-visible behaviour: a parked transfer and the kind
  // of data phase currently owed to the master.
  logic        m_hold;
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic        m_hlock;
  logic        m_in_slave;
  logic [3:0]  m_slave;
  int          m_err_left;

  logic        e_hready, e_hresp, e_prev, e_gtrans, e_gwrite, e_glock;
  logic [31:0] e_hrdata, e_gaddr;
  logic [2:0]  e_gsize;
  logic [15:0] e_addrsel, e_datasel;
  logic [3:0]  e_slv;
  logic        e_valid, e_mapped;

  // Advance to the next falling edge, passing one rising edge.
  task automatic cyc();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic set_idle_inputs();
    HADDR      = 32'd0;
    HTRANS     = 2'b00;
    HWRITE     = 1'b0;
    HSIZE      = 3'd0;
    HMASTLOCK  = 1'b0;
    SADDRREADY = 16'hFFFF;
    SDATAREADY = 16'hFFFF;
    SHRESP     = 16'h0000;
    for (int n = 0; n < 16; n++) SHRDATA[32*n +: 32] = 32'h0101_0101 * (n + 1);
    SHRDATA[127:96] = 32'hCAFE_F00D;
  endtask

  task automatic m_reset();
    m_hold     = 1'b0;
    m_haddr    = 32'd0;
    m_hwrite   = 1'b0;
    m_hsize    = 3'd0;
    m_hlock    = 1'b0;
    m_in_slave = 1'b0;
    m_slave    = 4'd0;
    m_err_left = 0;
  endtask

  task automatic model_eval();
    logic [31:0] la;
    logic [15:0] en;
    en       = SLAVE_EN_TB;
    la       = m_hold ? m_haddr : HADDR;
    e_slv    = la[31:28];
    e_mapped = en[e_slv];
    e_valid  = m_hold || HTRANS[1];
    e_gtrans = e_valid && e_mapped;
    e_addrsel = e_gtrans ? 16'(1 << int'(e_slv)) : 16'd0;
    e_gaddr  = la;
    e_gwrite = m_hold ? m_hwrite : HWRITE;
    e_gsize  = m_hold ? m_hsize : HSIZE;
    e_glock  = m_hold ? m_hlock : HMASTLOCK;
    e_hready = !m_hold;
    e_hresp  = 1'b0;
    e_hrdata = 32'd0;
    e_datasel = 16'd0;
    e_prev   = 1'b1;
    if (m_err_left == 2) begin
      e_hready = 1'b0;
      e_hresp  = 1'b1;
      e_prev   = 1'b0;
    end else if (m_err_left == 1) begin
      e_hready = 1'b1;
      e_hresp  = 1'b1;
    end else if (m_in_slave) begin
      e_prev    = SDATAREADY[m_slave];
      e_hready  = e_prev;
      e_hresp   = SHRESP[m_slave];
      e_hrdata  = 32'(SHRDATA >> (32 * int'(m_slave)));
      e_datasel = 16'(1 << int'(m_slave));
    end
  endtask

  task automatic model_advance();
    if (m_hold) begin
      if (SADDRREADY[e_slv]) begin
        m_hold     = 1'b0;
        m_in_slave = 1'b1;
        m_slave    = e_slv;
        m_err_left = 0;
      end
    end else if (e_hready) begin
      m_err_left = 0;
      m_in_slave = 1'b0;
      if (e_valid && e_mapped) begin
        if (SADDRREADY[e_slv]) begin
          m_in_slave = 1'b1;
          m_slave    = e_slv;
        end else begin
          m_hold   = 1'b1;
          m_haddr  = HADDR;
          m_hwrite = HWRITE;
          m_hsize  = HSIZE;
          m_hlock  = HMASTLOCK;
        end
      end else if (e_valid) begin
        m_err_left = 2;
      end
    end else if (m_err_left == 2) begin
      m_err_left = 1;
    end
  endtask

  task automatic test_reset();
    set_idle_inputs();
    HRESETN = 1'b0;
    HADDR   = 32'h3000_0000;
    HTRANS  = 2'b10;
    #2;
    n_checks++; if (HREADY !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_hready: got %b want 1", HREADY); end
    n_checks++; if (HRESP !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_hresp: got %b want 0", HRESP); end
    n_checks++; if (HRDATA !== 32'd0) begin n_errors++; $display("[TB] FAIL reset_hrdata: got %h want 0", HRDATA); end
    n_checks++; if (DATASEL !== 16'd0) begin n_errors++; $display("[TB] FAIL reset_datasel: got %h want 0", DATASEL); end
    n_checks++; if (PREVDATASLAVEREADY !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_prevready: got %b want 1", PREVDATASLAVEREADY); end
    n_checks++; if (ADDRSEL !== 16'h0008) begin n_errors++; $display("[TB] FAIL reset_addrsel: got %h want 0008", ADDRSEL); end
    n_checks++; if (GATEDHTRANS !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_gtrans: got %b want 1", GATEDHTRANS); end
    @(negedge HCLK);
    HRESETN = 1'b1;
    HTRANS  = 2'b00;
  endtask

  task automatic test_unmapped();
    HADDR  = 32'hA000_0000;
    HTRANS = 2'b10;
    #2;
    n_checks++; if (ADDRSEL !== 16'd0) begin n_errors++; $display("[TB] FAIL unmapped_addrsel: got %h want 0", ADDRSEL); end
    n_checks++; if (GATEDHTRANS !== 1'b0) begin n_errors++; $display("[TB] FAIL unmapped_gtrans: got %b want 0", GATEDHTRANS); end
    cyc();
    HTRANS = 2'b00;
    #2;
    n_checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin n_errors++; $display("[TB] FAIL unmapped_err1: got ready=%b resp=%b want 0/1", HREADY, HRESP); end
    n_checks++; if (PREVDATASLAVEREADY !== 1'b0) begin n_errors++; $display("[TB] FAIL unmapped_prev1: got %b want 0", PREVDATASLAVEREADY); end
    cyc();
    #2;
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin n_errors++; $display("[TB] FAIL unmapped_err2: got ready=%b resp=%b want 1/1", HREADY, HRESP); end
    cyc();
    #2;
    n_checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin n_errors++; $display("[TB] FAIL unmapped_done: got ready=%b resp=%b want 1/0", HREADY, HRESP); end
    cyc();
  endtask

  task automatic test_zero_wait();
    HADDR  = 32'h3000_0010;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    #2;
    n_checks++; if (ADDRSEL !== 16'h0008) begin n_errors++; $display("[TB] FAIL zw_addrsel: got %h want 0008", ADDRSEL); end
    n_checks++; if (GATEDHADDR !== 32'h3000_0010) begin n_errors++; $display("[TB] FAIL zw_gaddr: got %h want 30000010", GATEDHADDR); end
    cyc();
    HTRANS = 2'b00;
    #2;
    n_checks++; if (DATASEL !== 16'h0008) begin n_errors++; $display("[TB] FAIL zw_datasel: got %h want 0008", DATASEL); end
    n_checks++; if (HRDATA !== 32'hCAFE_F00D) begin n_errors++; $display("[TB] FAIL zw_hrdata: got %h want cafef00d", HRDATA); end
    n_checks++; if (HREADY !== 1'b1) begin n_errors++; $display("[TB] FAIL zw_hready: got %b want 1", HREADY); end
    cyc();
    #2;
    n_checks++; if (DATASEL !== 16'd0) begin n_errors++; $display("[TB] FAIL zw_idle_datasel: got %h want 0", DATASEL); end
    cyc();
  endtask

  task automatic test_lost_arb();
    SADDRREADY = 16'hFFDF;
    HADDR      = 32'h5000_0000;
    HTRANS     = 2'b10;
    HWRITE     = 1'b1;
    HSIZE      = 3'd2;
    HMASTLOCK  = 1'b1;
    #2;
    n_checks++; if (HREADY !== 1'b1 || ADDRSEL !== 16'h0020) begin n_errors++; $display("[TB] FAIL arb_sample: got ready=%b addrsel=%h want 1/0020", HREADY, ADDRSEL); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      HADDR     = 32'h6000_0000 + 32'(i * 4);
      HWRITE    = 1'b0;
      HSIZE     = 3'd0;
      HMASTLOCK = 1'b0;
      #2;
      n_checks++; if (HREADY !== 1'b0) begin n_errors++; $display("[TB] FAIL arb_hold_hready[%0d]: got %b want 0", i, HREADY); end
      n_checks++; if (GATEDHADDR !== 32'h5000_0000) begin n_errors++; $display("[TB] FAIL arb_hold_gaddr[%0d]: got %h want 50000000", i, GATEDHADDR); end
      n_checks++; if (GATEDHWRITE !== 1'b1 || GATEDHSIZE !== 3'd2 || GATEDHMASTLOCK !== 1'b1) begin n_errors++; $display("[TB] FAIL arb_hold_ctrl[%0d]: got w=%b s=%0d l=%b want 1/2/1", i, GATEDHWRITE, GATEDHSIZE, GATEDHMASTLOCK); end
      n_checks++; if (ADDRSEL !== 16'h0020) begin n_errors++; $display("[TB] FAIL arb_hold_addrsel[%0d]: got %h want 0020", i, ADDRSEL); end
      cyc();
    end
    SADDRREADY = 16'hFFFF;
    #2;
    n_checks++; if (HREADY !== 1'b0 || ADDRSEL !== 16'h0020) begin n_errors++; $display("[TB] FAIL arb_release: got ready=%b addrsel=%h want 0/0020", HREADY, ADDRSEL); end
    cyc();
    HTRANS = 2'b00;
    #2;
    n_checks++; if (DATASEL !== 16'h0020 || HREADY !== 1'b1) begin n_errors++; $display("[TB] FAIL arb_dphase: got datasel=%h ready=%b want 0020/1", DATASEL, HREADY); end
    n_checks++; if (GATEDHADDR !== HADDR || GATEDHTRANS !== 1'b0) begin n_errors++; $display("[TB] FAIL arb_live_master: got gaddr=%h gtrans=%b want %h/0", GATEDHADDR, GATEDHTRANS, HADDR); end
    cyc();
    set_idle_inputs();
  endtask

  task automatic test_wait_states();
    HADDR  = 32'h2000_0000;
    HTRANS = 2'b10;
    cyc();
    HADDR      = 32'h7000_0000;
    SDATAREADY = 16'hFFFB;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++; if (HREADY !== 1'b0 || PREVDATASLAVEREADY !== 1'b0) begin n_errors++; $display("[TB] FAIL wait_stall[%0d]: got ready=%b prev=%b want 0/0", i, HREADY, PREVDATASLAVEREADY); end
      n_checks++; if (DATASEL !== 16'h0004 || ADDRSEL !== 16'h0080) begin n_errors++; $display("[TB] FAIL wait_sel[%0d]: got datasel=%h addrsel=%h want 0004/0080", i, DATASEL, ADDRSEL); end
      cyc();
    end
    SDATAREADY = 16'hFFFF;
    #2;
    n_checks++; if (HREADY !== 1'b1 || DATASEL !== 16'h0004) begin n_errors++; $display("[TB] FAIL wait_done: got ready=%b datasel=%h want 1/0004", HREADY, DATASEL); end
    cyc();
    HTRANS = 2'b00;
    #2;
    n_checks++; if (DATASEL !== 16'h0080) begin n_errors++; $display("[TB] FAIL wait_next_dphase: got %h want 0080", DATASEL); end
    cyc();
  endtask

  task automatic test_slave_error();
    HADDR  = 32'h1000_0000;
    HTRANS = 2'b10;
    cyc();
    HTRANS     = 2'b00;
    SHRESP     = 16'h0002;
    SDATAREADY = 16'hFFFD;
    #2;
    n_checks++; if (HRESP !== 1'b1 || HREADY !== 1'b0) begin n_errors++; $display("[TB] FAIL serr_first: got resp=%b ready=%b want 1/0", HRESP, HREADY); end
    cyc();
    SDATAREADY = 16'hFFFF;
    #2;
    n_checks++; if (HRESP !== 1'b1 || HREADY !== 1'b1) begin n_errors++; $display("[TB] FAIL serr_second: got resp=%b ready=%b want 1/1", HRESP, HREADY); end
    cyc();
    SHRESP = 16'h0000;
    #2;
    n_checks++; if (HRESP !== 1'b0 || DATASEL !== 16'd0) begin n_errors++; $display("[TB] FAIL serr_done: got resp=%b datasel=%h want 0/0", HRESP, DATASEL); end
    cyc();
  endtask

  task automatic test_reset_mid();
    HADDR  = 32'h4000_0000;
    HTRANS = 2'b10;
    cyc();
    HTRANS     = 2'b00;
    SDATAREADY = 16'hFFEF;
    #2;
    n_checks++; if (DATASEL !== 16'h0010 || HREADY !== 1'b0) begin n_errors++; $display("[TB] FAIL rmid_pre: got datasel=%h ready=%b want 0010/0", DATASEL, HREADY); end
    HRESETN = 1'b0;
    #1;
    n_checks++; if (HREADY !== 1'b1 || DATASEL !== 16'd0 || PREVDATASLAVEREADY !== 1'b1) begin n_errors++; $display("[TB] FAIL rmid_slave: got ready=%b datasel=%h prev=%b want 1/0/1", HREADY, DATASEL, PREVDATASLAVEREADY); end
    @(negedge HCLK);
    HRESETN    = 1'b1;
    SDATAREADY = 16'hFFFF;
    SADDRREADY = 16'hFFBF;
    HADDR      = 32'h6000_0000;
    HTRANS     = 2'b10;
    HWRITE     = 1'b1;
    cyc();
    HADDR  = 32'h0000_0100;
    HTRANS = 2'b00;
    #2;
    n_checks++; if (HREADY !== 1'b0 || GATEDHADDR !== 32'h6000_0000) begin n_errors++; $display("[TB] FAIL rmid_hold_pre: got ready=%b gaddr=%h want 0/60000000", HREADY, GATEDHADDR); end
    HRESETN = 1'b0;
    #1;
    n_checks++; if (HREADY !== 1'b1 || GATEDHADDR !== 32'h0000_0100 || ADDRSEL !== 16'd0) begin n_errors++; $display("[TB] FAIL rmid_hold: got ready=%b gaddr=%h addrsel=%h want 1/00000100/0", HREADY, GATEDHADDR, ADDRSEL); end
    @(negedge HCLK);
    HRESETN = 1'b1;
    set_idle_inputs();
    cyc();
  endtask

  task automatic test_random();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!HRESETN) HRESETN = 1'b1;
      else if ($urandom_range(0, 99) == 0) HRESETN = 1'b0;
      HADDR      = $urandom;
      HTRANS     = 2'($urandom_range(0, 3));
      HWRITE     = 1'($urandom_range(0, 1));
      HSIZE      = 3'($urandom_range(0, 7));
      HMASTLOCK  = 1'($urandom_range(0, 1));
      SADDRREADY = 16'($urandom | $urandom);
      SDATAREADY = 16'($urandom | $urandom);
      SHRESP     = 16'($urandom & $urandom & $urandom);
      for (int n = 0; n < 16; n++) SHRDATA[32*n +: 32] = $urandom;
      if (!HRESETN) m_reset();
      #2;
      model_eval();
      n_checks++; if (HREADY !== e_hready) begin n_errors++; $display("[TB] FAIL rnd_hready c=%0d: got %b want %b", c, HREADY, e_hready); end
      n_checks++; if (HRESP !== e_hresp) begin n_errors++; $display("[TB] FAIL rnd_hresp c=%0d: got %b want %b", c, HRESP, e_hresp); end
      n_checks++; if (HRDATA !== e_hrdata) begin n_errors++; $display("[TB] FAIL rnd_hrdata c=%0d: got %h want %h", c, HRDATA, e_hrdata); end
      n_checks++; if (DATASEL !== e_datasel) begin n_errors++; $display("[TB] FAIL rnd_datasel c=%0d: got %h want %h", c, DATASEL, e_datasel); end
      n_checks++; if (PREVDATASLAVEREADY !== e_prev) begin n_errors++; $display("[TB] FAIL rnd_prev c=%0d: got %b want %b", c, PREVDATASLAVEREADY, e_prev); end
      n_checks++; if (ADDRSEL !== e_addrsel) begin n_errors++; $display("[TB] FAIL rnd_addrsel c=%0d: got %h want %h", c, ADDRSEL, e_addrsel); end
      n_checks++; if (GATEDHTRANS !== e_gtrans) begin n_errors++; $display("[TB] FAIL rnd_gtrans c=%0d: got %b want %b", c, GATEDHTRANS, e_gtrans); end
      n_checks++; if (GATEDHADDR !== e_gaddr) begin n_errors++; $display("[TB] FAIL rnd_gaddr c=%0d: got %h want %h", c, GATEDHADDR, e_gaddr); end
      n_checks++; if (GATEDHWRITE !== e_gwrite || GATEDHSIZE !== e_gsize || GATEDHMASTLOCK !== e_glock) begin n_errors++; $display("[TB] FAIL rnd_gctrl c=%0d: got %b/%0d/%b want %b/%0d/%b", c, GATEDHWRITE, GATEDHSIZE, GATEDHMASTLOCK, e_gwrite, e_gsize, e_glock); end
      if (HRESETN) model_advance();
      cyc();
    end
    HRESETN = 1'b1;
    set_idle_inputs();
  endtask

  initial begin
    $display("[TB] starting ahblite_master_stage bench");
    test_reset();
    test_unmapped();
    test_zero_wait();
    test_lost_arb();
    test_wait_states();
    test_slave_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
